cmplx_res_acc: RTL and testbench

//  Downstream consumer of the complex multiplier result stream (res_val/res_rdy/res_data).

---
 rtl/cmplx_res_acc.sv | 194 +++++++++++++++++++
 tb/tb_cmplx_res_acc.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmplx_res_acc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cmplx_res_acc
//
// Purpose:
//   Consumes the complex multiplier result stream and adds up cfg_len
//   consecutive complex products into one complex sum (dot-product style).
//   The sum is offered on a valid/ready output stream. The real and imaginary
//   parts accumulate independently in exact two's complement arithmetic. The
//   output is CW bits wider than a product, so a full frame cannot overflow.
//
// Ports:
//   clk       in   1          system clock, all logic on rising edge
//   rst_n     in   1          asynchronous active-low reset
//   sw_rst    in   1          synchronous soft reset, active high, overrides all
//   cfg_len   in   LW         products per frame (0 -> 1, >MAX_LEN -> MAX_LEN)
//   res_val   in   1          product valid
//   res_rdy   out  1          product ready (registered)
//   res_data  in   2*PWIDTH   {im, re}, signed products
//   acc_val   out  1          sum valid (registered)
//   acc_rdy   in   1          sum ready from consumer
//   acc_data  out  2*OWIDTH   {im_sum, re_sum}, signed
//   frm_cnt   out  16         completed-frame counter, wraps
// -----------------------------------------------------------------------------
module cmplx_res_acc #(
    parameter  int DWIDTH  = 8,
    parameter  int MAX_LEN = 4,
    localparam int LW      = $clog2(MAX_LEN + 1),
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int PWIDTH  = 2 * DWIDTH + 2,
    localparam int OWIDTH  = PWIDTH + CW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sw_rst,
    input  logic [LW-1:0]       cfg_len,
    input  logic                res_val,
    output logic                res_rdy,
    input  logic [2*PWIDTH-1:0] res_data,
    output logic                acc_val,
    input  logic                acc_rdy,
    output logic [2*OWIDTH-1:0] acc_data,
    output logic [15:0]         frm_cnt
);

    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Frame length used for a new frame: 0 means a single product, anything
    // beyond MAX_LEN is capped.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        logic [LW-1:0] r;
        if (len == '0) begin
            r = LW'(1);
        end else if (len > LEN_MAX) begin
            r = LEN_MAX;
        end else begin
            r = len;
        end
        return r;
    endfunction

    function automatic logic signed [OWIDTH-1:0] sext(input logic signed [PWIDTH-1:0] v);
        return {{CW{v[PWIDTH-1]}}, v};
    endfunction

    state_t                   state_q, state_d;
    logic                     res_rdy_q, res_rdy_d;
    logic                     acc_val_q, acc_val_d;
    logic [15:0]              frm_cnt_q, frm_cnt_d;
    logic [LW-1:0]            cnt_q, cnt_d;
    logic [LW-1:0]            len_q, len_d;
    logic signed [OWIDTH-1:0] sum_re_q, sum_im_q;
    logic signed [OWIDTH-1:0] out_re_q, out_re_d;
    logic signed [OWIDTH-1:0] out_im_q, out_im_d;

    logic signed [PWIDTH-1:0] smp_re, smp_im;
    logic signed [OWIDTH-1:0] add_re, add_im;
    logic [LW-1:0]            len_eff;
    logic                     hs;
    logic                     last;

    assign smp_re = res_data[PWIDTH-1:0];
    assign smp_im = res_data[2*PWIDTH-1:PWIDTH];

    // res_rdy_q is only ever high in ACCUM, so it alone qualifies the input.
    assign hs = res_val & res_rdy_q;

    // The first product of a frame both latches the length and is allowed to
    // be the last one (length 1), so the live clamped cfg_len is used there.
    assign len_eff = (cnt_q == '0) ? clamp_len(cfg_len) : len_q;
    assign last    = hs && (cnt_q == len_eff - LW'(1));

    // First product reloads the accumulator, discarding any stale partial sum.
    assign add_re = (cnt_q == '0) ? sext(smp_re) : sum_re_q + sext(smp_re);
    assign add_im = (cnt_q == '0) ? sext(smp_im) : sum_im_q + sext(smp_im);

    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_ACCUM;
            S_ACCUM: if (last) state_d = S_HOLD;
            S_HOLD:  if (acc_rdy) state_d = S_ACCUM;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : fsm_out
        res_rdy_d = (state_d == S_ACCUM);
        acc_val_d = (state_d == S_HOLD);
        frm_cnt_d = frm_cnt_q;
        if ((state_q == S_HOLD) && acc_rdy) begin
            frm_cnt_d = frm_cnt_q + 16'd1;
        end
    end

    always_comb begin : dp_next
        cnt_d    = cnt_q;
        len_d    = len_q;
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        if (hs) begin
            if (cnt_q == '0) begin
                len_d = len_eff;
            end
            if (last) begin
                cnt_d    = '0;
                out_re_d = add_re;
                out_im_d = add_im;
            end else begin
                cnt_d = cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : ctrl_reg
        if (!rst_n) begin
            state_q   <= S_IDLE;
            res_rdy_q <= 1'b0;
            acc_val_q <= 1'b0;
            frm_cnt_q <= '0;
            cnt_q     <= '0;
            len_q     <= LW'(1);
        end else if (sw_rst) begin
            state_q   <= S_IDLE;
            res_rdy_q <= 1'b0;
            acc_val_q <= 1'b0;
            frm_cnt_q <= '0;
            cnt_q     <= '0;
            len_q     <= LW'(1);
        end else begin
            state_q   <= state_d;
            res_rdy_q <= res_rdy_d;
            acc_val_q <= acc_val_d;
            frm_cnt_q <= frm_cnt_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
        end
    end

    // Output sum register: only loaded on the last product of a frame, so it
    // stays stable for the whole HOLD period.
    always_ff @(posedge clk or negedge rst_n) begin : out_reg
        if (!rst_n) begin
            out_re_q <= '0;
            out_im_q <= '0;
        end else if (sw_rst) begin
            out_re_q <= '0;
            out_im_q <= '0;
        end else begin
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
        end
    end

    // Running sums need no reset: a cleared cnt_q forces a reload.
    always_ff @(posedge clk) begin : sum_reg
        if (hs) begin
            sum_re_q <= add_re;
            sum_im_q <= add_im;
        end
    end

    assign res_rdy  = res_rdy_q;
    assign acc_val  = acc_val_q;
    assign acc_data = {out_im_q, out_re_q};
    assign frm_cnt  = frm_cnt_q;

endmodule

// File: tb/tb_cmplx_res_acc.sv
`timescale 1ns/1ps
module tb_cmplx_res_acc;

    localparam int PW = 18;
    localparam int OW = 20;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sw_rst = 1'b0;
    logic [2:0]      cfg_len = 3'd4;
    logic            res_val = 1'b0;
    logic            res_rdy;
    logic [2*PW-1:0] res_data = '0;
    logic            acc_val;
    logic            acc_rdy = 1'b0;
    logic [2*OW-1:0] acc_data;
    logic [15:0]     frm_cnt;

    int checks = 0;
    int errors = 0;

    cmplx_res_acc #(.DWIDTH(8), .MAX_LEN(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_rst   (sw_rst),
        .cfg_len  (cfg_len),
        .res_val  (res_val),
        .res_rdy  (res_rdy),
        .res_data (res_data),
        .acc_val  (acc_val),
        .acc_rdy  (acc_rdy),
        .acc_data (acc_data),
        .frm_cnt  (frm_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Predicts, from the inputs seen before each rising edge, what the
    // outputs must be after that edge. Frames are collected in queues and
    // summed with plain integer arithmetic.
    logic        m_idle = 1'b1;
    logic        m_hold = 1'b0;
    logic        e_res_rdy = 1'b0;
    logic        e_acc_val = 1'b0;
    int          e_re = 0;
    int          e_im = 0;
    logic [15:0] e_frm = '0;
    int          q_re[$];
    int          q_im[$];
    int          m_len = 1;
    int          s_re, s_im;

    function automatic int clamp(input int l);
        int r;
        r = l;
        if (l == 0) r = 1;
        if (l > 4) r = 4;
        return r;
    endfunction

    task m_reset();
        m_idle = 1'b1;
        m_hold = 1'b0;
        e_res_rdy = 1'b0;
        e_acc_val = 1'b0;
        e_re = 0;
        e_im = 0;
        e_frm = '0;
        m_len = 1;
        q_re.delete();
        q_im.delete();
    endtask

    task m_step();
        if (sw_rst) begin
            m_reset();
        end else if (m_idle) begin
            m_idle = 1'b0;
            e_res_rdy = 1'b1;
        end else if (m_hold) begin
            if (acc_rdy) begin
                m_hold = 1'b0;
                e_acc_val = 1'b0;
                e_res_rdy = 1'b1;
                e_frm = e_frm + 16'd1;
            end
        end else if (res_val) begin
            q_re.push_back(int'($signed(res_data[PW-1:0])));
            q_im.push_back(int'($signed(res_data[2*PW-1:PW])));
            if (q_re.size() == 1) m_len = clamp(int'(cfg_len));
            if (q_re.size() == m_len) begin
                s_re = 0;
                s_im = 0;
                foreach (q_re[i]) begin
                    s_re += q_re[i];
                    s_im += q_im[i];
                end
                e_re = s_re;
                e_im = s_im;
                e_acc_val = 1'b1;
                e_res_rdy = 1'b0;
                m_hold = 1'b1;
                q_re.delete();
                q_im.delete();
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) m_reset();
        chk("mdl_res_rdy", res_rdy, e_res_rdy);
        chk("mdl_acc_val", acc_val, e_acc_val);
        chk("mdl_acc_re", $signed(acc_data[OW-1:0]), e_re);
        chk("mdl_acc_im", $signed(acc_data[2*OW-1:OW]), e_im);
        chk("mdl_frm_cnt", frm_cnt, e_frm);
        if (rst_n) m_step();
    end

    // ---------------- stimulus helpers ----------------
    task step();
        @(posedge clk);
        #1;
    endtask

    task send(input int re, input int im, input int gap);
        int n;
        res_val = 1'b0;
        repeat (gap) begin
            res_data = {4'($urandom), $urandom};
            step();
        end
        res_val = 1'b1;
        res_data = {18'(im), 18'(re)};
        n = 0;
        while (!res_rdy && n < 64) begin
            step();
            n++;
        end
        chk("send_rdy", res_rdy, 1);
        step();
        res_val = 1'b0;
    endtask

    task consume();
        acc_rdy = 1'b1;
        step();
        acc_rdy = 1'b0;
    endtask

    task expect_out(input string name, input int re, input int im);
        chk({name, "_val"}, acc_val, 1);
        chk({name, "_re"}, $signed(acc_data[OW-1:0]), re);
        chk({name, "_im"}, $signed(acc_data[2*OW-1:OW]), im);
    endtask

    function automatic logic [17:0] rnd18();
        logic [17:0] r;
        case ($urandom % 4)
            0:       r = 18'h20000;
            1:       r = 18'h1FFFF;
            default: r = 18'($urandom);
        endcase
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_res_rdy", res_rdy, 0);
        chk("rst_acc_val", acc_val, 0);
        chk("rst_acc_data", acc_data, 0);
        chk("rst_frm_cnt", frm_cnt, 0);
        rst_n = 1'b1;
        step();
        chk("accum_after_idle", res_rdy, 1);

        // 1: basic frame, back to back, consumer always ready
        cfg_len = 3'd4;
        acc_rdy = 1'b1;
        send(1, 2, 0);
        send(3, -4, 0);
        send(-5, 6, 0);
        send(7, 8, 0);
        expect_out("s1", 6, 12);
        step();
        chk("s1_val_drop", acc_val, 0);
        chk("s1_frm_cnt", frm_cnt, 1);
        chk("s1_rdy_back", res_rdy, 1);
        acc_rdy = 1'b0;

        // 2: extreme products, no wrap
        repeat (4) send(-131072, 131071, 0);
        chk("s2_re_raw", acc_data[OW-1:0], 'h80000);
        chk("s2_im_raw", acc_data[2*OW-1:OW], 'h7FFFC);

        // 3: backpressure in HOLD
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s3_hold_val", acc_val, 1);
            chk("s3_hold_rdy", res_rdy, 0);
            chk("s3_hold_data", acc_data, 40'h7FFFC_80000);
        end
        acc_rdy = 1'b1;
        step();
        acc_rdy = 1'b0;
        chk("s3_release_val", acc_val, 0);
        chk("s3_release_rdy", res_rdy, 1);
        chk("s3_frm_cnt", frm_cnt, 2);

        // 4: length clamping
        cfg_len = 3'd1;
        send(9, -9, 0);
        expect_out("s4_len1", 9, -9);
        consume();
        cfg_len = 3'd0;
        send(1, 1, 0);
        expect_out("s4_len0", 1, 1);
        consume();
        cfg_len = 3'd7;
        repeat (3) send(1, 2, 0);
        chk("s4_len7_not_yet", acc_val, 0);
        send(1, 2, 0);
        expect_out("s4_len7", 4, 8);
        consume();

        // 5: soft reset mid-frame, cfg_len change mid-frame
        cfg_len = 3'd4;
        send(5, 5, 0);
        send(5, 5, 0);
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        chk("s5_sw_rdy", res_rdy, 0);
        chk("s5_sw_val", acc_val, 0);
        chk("s5_sw_frm", frm_cnt, 0);
        step();
        chk("s5_sw_accum", res_rdy, 1);
        send(1, 1, 0);
        cfg_len = 3'd1;
        send(1, 1, 0);
        chk("s5_len_ignored", acc_val, 0);
        send(1, 1, 0);
        send(1, 1, 0);
        expect_out("s5", 4, 4);
        consume();
        chk("s5_frm_cnt", frm_cnt, 1);

        // 6: asynchronous reset while holding a result
        cfg_len = 3'd1;
        send(3, 3, 0);
        chk("s6_in_hold", acc_val, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_val", acc_val, 0);
        chk("s6_async_rdy", res_rdy, 0);
        chk("s6_async_data", acc_data, 0);
        chk("s6_async_frm", frm_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        cfg_len = 3'd4;
        send(1, 2, $urandom_range(0, 5));
        send(3, -4, $urandom_range(0, 5));
        send(-5, 6, $urandom_range(0, 5));
        send(7, 8, $urandom_range(0, 5));
        expect_out("s6_gaps", 6, 12);
        consume();

        // random traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            res_val  = ($urandom % 4) != 0;
            res_data = {rnd18(), rnd18()};
            acc_rdy  = ($urandom % 3) == 0;
            cfg_len  = 3'($urandom);
            sw_rst   = ($urandom % 150) == 0;
            step();
        end
        res_val = 1'b0;
        acc_rdy = 1'b0;
        sw_rst  = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
